arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester.sv | 98 +++++++++
 tb/tb_arb_requester.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// Per-client job counters that raise requests toward a shared arbiter,
// with starvation tracking and a sticky grant-protocol error flag.
module arb_requester #(
  parameter int CLIENTS  = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] push,
  output logic [CLIENTS-1:0] push_ready,
  output logic [CLIENTS-1:0] request,
  input  logic [CLIENTS-1:0] grant,
  input  logic               stall,
  input  logic               starved_clear,
  output logic [CLIENTS-1:0] starved,
  output logic               protocol_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);
  localparam logic [CLIENTS-1:0] ONE = CLIENTS'(1);

  logic [CW-1:0]      cnt_q [CLIENTS];
  logic [CW-1:0]      cnt_d [CLIENTS];
  logic [AW-1:0]      age_q [CLIENTS];
  logic [AW-1:0]      age_d [CLIENTS];
  logic [CLIENTS-1:0] starved_q, starved_d;
  logic               perr_q, perr_d;

  logic [CLIENTS-1:0] accept;
  logic [CLIENTS-1:0] consume;
  logic [CLIENTS-1:0] set_starve;
  logic               grant_multi;

  always_comb begin
    request     = '0;
    push_ready  = '0;
    grant_multi = |(grant & (grant - ONE));
    for (int i = 0; i < CLIENTS; i++) begin
      request[i]    = cnt_q[i] != '0;
      push_ready[i] = cnt_q[i] < DEPTH_C;
    end
    accept  = push & push_ready;
    // A multi-hot grant is rejected as a whole, so no counter moves.
    consume = grant & request & {CLIENTS{~stall & ~grant_multi}};
    perr_d  = perr_q
            | (~stall & (grant_multi | (|(grant & ~request))));
  end

  always_comb begin
    set_starve = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept[i] && !consume[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (consume[i] && !accept[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end

      age_d[i] = age_q[i];
      if (!request[i] || consume[i] || starved_clear) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end

      set_starve[i] = request[i] & ~consume[i] & ~starved_q[i]
                    & (age_q[i] == AGE_MAX);
    end
    starved_d = set_starve
              | (starved_q & ~{CLIENTS{starved_clear}});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CLIENTS; i++) begin
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
      starved_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
        age_q[i] <= age_d[i];
      end
      starved_q <= starved_d;
      perr_q    <= perr_d;
    end
  end

  assign starved      = starved_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: request/push_ready flow,
// starvation flags, grant protocol errors and async reset.
module tb_arb_requester;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] push, push_ready, request, grant, starved;
  logic         stall, starved_clear, protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  arb_requester #(.CLIENTS(N), .DEPTH(4), .MAX_WAIT(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .push_ready   (push_ready),
    .request      (request),
    .grant        (grant),
    .stall        (stall),
    .starved_clear(starved_clear),
    .starved      (starved),
    .protocol_err (protocol_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    push          = '0;
    grant         = '0;
    stall         = 1'b0;
    starved_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #2;
    n_checks++;
    if (request !== '0) begin
      n_fail++;
      $display("FAIL rst_request got %h want 0", request);
    end
    n_checks++;
    if (push_ready !== '1) begin
      n_fail++;
      $display("FAIL rst_push_ready got %h want ffffffff", push_ready);
    end
    n_checks++;
    if (starved !== '0 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got starved=%h perr=%b want 0/0",
               starved, protocol_err);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    push = 32'h10;
    tick();
    push = '0;
    n_checks++;
    if (request !== 32'h10) begin
      n_fail++;
      $display("FAIL single_req_up got %h want 00000010", request);
    end
    grant = 32'h10;
    tick();
    grant = '0;
    n_checks++;
    if (request !== '0) begin
      n_fail++;
      $display("FAIL single_req_down got %h want 0", request);
    end
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_perr got %b want 0", protocol_err);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 5; k++) begin
      push = 32'h1;
      tick();
      n_checks++;
      if (push_ready[0] !== (k < 4)) begin
        n_fail++;
        $display("FAIL fill_ready push %0d got %b want %b",
                 k, push_ready[0], (k < 4));
      end
    end
    push = '0;
    for (int k = 1; k <= 4; k++) begin
      grant = 32'h1;
      tick();
      n_checks++;
      if (request[0] !== (k < 4)) begin
        n_fail++;
        $display("FAIL fill_drain grant %0d got %b want %b",
                 k, request[0], (k < 4));
      end
    end
    grant = '0;
  endtask

  task automatic test_full_push_grant();
    push = 32'h2;
    repeat (4) tick();
    push = '0;
    n_checks++;
    if (push_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready got %b want 0", push_ready[1]);
    end
    push  = 32'h2;
    grant = 32'h2;
    tick();
    push = '0;
    n_checks++;
    if (push_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pg_ready got %b want 1", push_ready[1]);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (request[1] !== (k < 3)) begin
        n_fail++;
        $display("FAIL full_pg_drain grant %0d got %b want %b",
                 k, request[1], (k < 3));
      end
    end
    grant = '0;
  endtask

  task automatic test_stall_ignore();
    push = 32'h3;
    tick();
    push  = '0;
    stall = 1'b1;
    grant = 32'h83;
    repeat (3) tick();
    n_checks++;
    if (protocol_err !== 1'b0 || request !== 32'h3) begin
      n_fail++;
      $display("FAIL stall_ignore got perr=%b req=%h want 0/00000003",
               protocol_err, request);
    end
    stall = 1'b0;
    grant = '0;
  endtask

  task automatic test_protocol();
    grant = 32'h3;
    tick();
    grant = '0;
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_multi got %b want 1", protocol_err);
    end
    n_checks++;
    if (request !== 32'h3) begin
      n_fail++;
      $display("FAIL perr_multi_req got %h want 00000003", request);
    end
    grant = 32'h1;
    tick();
    n_checks++;
    if (request !== 32'h2) begin
      n_fail++;
      $display("FAIL perr_cnt_kept got %h want 00000002", request);
    end
    grant = 32'h2;
    tick();
    grant = '0;
    n_checks++;
    if (request !== '0 || protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_sticky got req=%h perr=%b want 0/1",
               request, protocol_err);
    end
    do_reset();
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_reset got %b want 0", protocol_err);
    end
    grant = 32'h80;
    tick();
    grant = '0;
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_noreq got %b want 1", protocol_err);
    end
    do_reset();
  endtask

  task automatic test_starve();
    bit bad;
    push = 32'h4;
    tick();
    push  = '0;
    stall = 1'b1;
    grant = 32'h4;
    bad = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (starved !== '0 || request !== 32'h4) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL starve_early got bad=%b want 0", bad);
    end
    tick();
    n_checks++;
    if (starved !== 32'h4) begin
      n_fail++;
      $display("FAIL starve_set got %h want 00000004", starved);
    end
    starved_clear = 1'b1;
    tick();
    starved_clear = 1'b0;
    n_checks++;
    if (starved !== '0) begin
      n_fail++;
      $display("FAIL starve_clear got %h want 0", starved);
    end
    bad = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (starved !== '0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL starve_reearly got bad=%b want 0", bad);
    end
    tick();
    n_checks++;
    if (starved !== 32'h4 || request !== 32'h4) begin
      n_fail++;
      $display("FAIL starve_reset got st=%h req=%h want 4/4",
               starved, request);
    end
    stall = 1'b0;
    tick();
    grant = '0;
    n_checks++;
    if (request !== '0 || starved !== 32'h4 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_grant got req=%h st=%h perr=%b want 0/4/0",
               request, starved, protocol_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push = 32'h8;
    tick();
    tick();
    push  = '0;
    stall = 1'b1;
    repeat (33) tick();
    n_checks++;
    if (starved !== 32'h8 || request !== 32'h8) begin
      n_fail++;
      $display("FAIL mid_setup got st=%h req=%h want 8/8",
               starved, request);
    end
    grant = 32'h80;
    stall = 1'b0;
    tick();
    grant = '0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (request !== '0 || starved !== '0 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async got req=%h st=%h perr=%b want 0/0/0",
               request, starved, protocol_err);
    end
    push          = 32'h8;
    grant         = 32'h8;
    starved_clear = 1'b1;
    tick();
    n_checks++;
    if (request !== '0 || push_ready !== '1) begin
      n_fail++;
      $display("FAIL mid_held got req=%h rdy=%h want 0/ffffffff",
               request, push_ready);
    end
    idle();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (request !== '0) begin
      n_fail++;
      $display("FAIL mid_discard got %h want 0", request);
    end
    push = 32'h8;
    tick();
    push = '0;
    n_checks++;
    if (request !== 32'h8) begin
      n_fail++;
      $display("FAIL mid_repush got %h want 00000008", request);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_fill();
    test_full_push_grant();
    test_stall_ignore();
    test_protocol();
    test_starve();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
